// File: rtl/collision_detector_pkg.sv
// Shared constants and types for the smiley collision-event producer.
package collision_detector_pkg;

    localparam int unsigned LIFE_INIT      = 3;
    localparam int unsigned N_OBSTACLES    = 8;
    localparam int unsigned HOLDOFF_FRAMES = 4;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned HOLDOFF_W      = 4;

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } bottom_state_e;

endpackage

// File: rtl/collision_detector_obstacle_priority_encoder.sv
// Lowest-set-bit finder over obstacle lines: 4-bit index plus any-set flag.
module obstacle_priority_encoder #(
    parameter int unsigned N_OBSTACLES = 8
) (
    input  logic [N_OBSTACLES-1:0] req,
    output logic [3:0]             index,
    output logic                   any
);
    import collision_detector_pkg::*;

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        any   = |req;
        for (int i = int'(N_OBSTACLES) - 1; i >= 0; i--) begin
            if (req[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/collision_detector.sv
// Accumulates smiley/bottom and smiley/obstacle overlaps per frame and emits
// one-cycle collision pulses one clock after each startOfFrame.
module collision_detector #(
    parameter int unsigned N_OBSTACLES    = collision_detector_pkg::N_OBSTACLES,
    parameter int unsigned HOLDOFF_FRAMES = collision_detector_pkg::HOLDOFF_FRAMES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   pause,
    input  logic                   smileyDR,
    input  logic                   borderBottomDR,
    input  logic [N_OBSTACLES-1:0] obstacleDR,
    output logic                   collisionSmileyBorderBottom,
    output logic                   collisionSmileyObstacle,
    output logic                   collisionSmileyObstacleReal,
    output logic [3:0]             obstacleIndex
);
    import collision_detector_pkg::*;

    bottom_state_e          state_q, state_d;
    logic [HOLDOFF_W-1:0]   holdoff_q, holdoff_d;
    logic                   acc_bottom_q, acc_bottom_d;
    logic [N_OBSTACLES-1:0] acc_obs_q, acc_obs_d;
    logic [N_OBSTACLES-1:0] prev_hit_q, prev_hit_d;
    logic                   pulse_bottom_d, pulse_obs_d, pulse_real_d;
    logic [IDX_W-1:0]       index_d;

    logic                   bottom_term;
    logic [N_OBSTACLES-1:0] obs_term;
    logic [N_OBSTACLES-1:0] new_hit;
    logic [IDX_W-1:0]       new_idx;
    logic                   new_any;

    assign bottom_term = smileyDR & borderBottomDR;
    assign obs_term    = {N_OBSTACLES{smileyDR}} & obstacleDR;
    assign new_hit     = acc_obs_q & ~prev_hit_q;

    obstacle_priority_encoder #(
        .N_OBSTACLES (N_OBSTACLES)
    ) u_new_hit_enc (
        .req   (new_hit),
        .index (new_idx),
        .any   (new_any)
    );

    // Next-state: accumulate, evaluate at frame boundary, bottom holdoff FSM.
    always_comb begin
        state_d        = state_q;
        holdoff_d      = holdoff_q;
        acc_bottom_d   = acc_bottom_q | bottom_term;
        acc_obs_d      = acc_obs_q | obs_term;
        prev_hit_d     = prev_hit_q;
        pulse_bottom_d = 1'b0;
        pulse_obs_d    = 1'b0;
        pulse_real_d   = 1'b0;
        index_d        = obstacleIndex;

        if (pause) begin
            // Keep history empty so resuming reports only fresh contact.
            acc_bottom_d = 1'b0;
            acc_obs_d    = '0;
            prev_hit_d   = '0;
        end else if (startOfFrame) begin
            acc_bottom_d = bottom_term;
            acc_obs_d    = obs_term;
            prev_hit_d   = acc_obs_q;
            pulse_obs_d  = |acc_obs_q;
            pulse_real_d = new_any;
            if (new_any) index_d = new_idx;

            case (state_q)
                ARMED: begin
                    if (acc_bottom_q) begin
                        pulse_bottom_d = 1'b1;
                        holdoff_d      = HOLDOFF_W'(HOLDOFF_FRAMES);
                        state_d        = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (holdoff_q > HOLDOFF_W'(1)) begin
                        holdoff_d = holdoff_q - HOLDOFF_W'(1);
                    end else begin
                        holdoff_d = '0;
                        state_d   = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                     <= ARMED;
            holdoff_q                   <= '0;
            acc_bottom_q                <= 1'b0;
            acc_obs_q                   <= '0;
            prev_hit_q                  <= '0;
            collisionSmileyBorderBottom <= 1'b0;
            collisionSmileyObstacle     <= 1'b0;
            collisionSmileyObstacleReal <= 1'b0;
            obstacleIndex               <= '0;
        end else begin
            state_q                     <= state_d;
            holdoff_q                   <= holdoff_d;
            acc_bottom_q                <= acc_bottom_d;
            acc_obs_q                   <= acc_obs_d;
            prev_hit_q                  <= prev_hit_d;
            collisionSmileyBorderBottom <= pulse_bottom_d;
            collisionSmileyObstacle     <= pulse_obs_d;
            collisionSmileyObstacleReal <= pulse_real_d;
            obstacleIndex               <= index_d;
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector with hand-computed boundary results.
module tb_collision_detector;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         startOfFrame;
    logic         pause;
    logic         smileyDR;
    logic         borderBottomDR;
    logic [N-1:0] obstacleDR;
    logic         collisionSmileyBorderBottom;
    logic         collisionSmileyObstacle;
    logic         collisionSmileyObstacleReal;
    logic [3:0]   obstacleIndex;

    int checks = 0;
    int errors = 0;

    collision_detector #(
        .N_OBSTACLES    (N),
        .HOLDOFF_FRAMES (4)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .startOfFrame                (startOfFrame),
        .pause                       (pause),
        .smileyDR                    (smileyDR),
        .borderBottomDR              (borderBottomDR),
        .obstacleDR                  (obstacleDR),
        .collisionSmileyBorderBottom (collisionSmileyBorderBottom),
        .collisionSmileyObstacle     (collisionSmileyObstacle),
        .collisionSmileyObstacleReal (collisionSmileyObstacleReal),
        .obstacleIndex               (obstacleIndex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Packed observation: {bottom, obstacle, real, index[3:0]}.
    function automatic logic [31:0] outs();
        return {25'd0, collisionSmileyBorderBottom, collisionSmileyObstacle,
                collisionSmileyObstacleReal, obstacleIndex};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int n, input logic bot, input logic [N-1:0] obs);
        smileyDR       = 1'b1;
        borderBottomDR = bot;
        obstacleDR     = obs;
        repeat (n) tick();
        smileyDR       = 1'b0;
        borderBottomDR = 1'b0;
        obstacleDR     = '0;
        repeat (2) tick();
    endtask

    // Drive one startOfFrame pixel, check the registered result and its 1-cycle width.
    task automatic boundary(input string tag, input logic [N-1:0] sof_obs,
                            input logic b, input logic o, input logic r, input logic [3:0] idx);
        startOfFrame = 1'b1;
        smileyDR     = (sof_obs != '0);
        obstacleDR   = sof_obs;
        tick();
        check(tag, outs(), {25'd0, b, o, r, idx});
        startOfFrame = 1'b0;
        smileyDR     = 1'b0;
        obstacleDR   = '0;
        tick();
        check({tag, "_width"}, outs() & 32'h70, 32'h0);
    endtask

    initial begin
        reset          = 1'b1;
        startOfFrame   = 1'b1;
        pause          = 1'b0;
        smileyDR       = 1'b1;
        borderBottomDR = 1'b1;
        obstacleDR     = 8'hFF;
        tick();
        tick();
        check("reset_init", outs(), 32'h0);
        reset          = 1'b0;
        startOfFrame   = 1'b0;
        smileyDR       = 1'b0;
        borderBottomDR = 1'b0;
        obstacleDR     = '0;
        tick();

        boundary("b0", '0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Bottom every frame for 8 frames: pulses after frame 0 and frame 5.
        for (int f = 0; f < 8; f++) begin
            pixels(3, 1'b1, '0);
            boundary($sformatf("bottom_f%0d", f), '0, (f == 0 || f == 5), 1'b0, 1'b0, 4'd0);
        end
        boundary("drain1", '0, 1'b0, 1'b0, 1'b0, 4'd0);
        boundary("drain2", '0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Obstacle 3 for 10 px, sustained three frames.
        pixels(10, 1'b0, 8'h08);
        boundary("obs3_first", '0, 1'b0, 1'b1, 1'b1, 4'd3);
        pixels(10, 1'b0, 8'h08);
        boundary("obs3_sust1", '0, 1'b0, 1'b1, 1'b0, 4'd3);
        pixels(10, 1'b0, 8'h08);
        boundary("obs3_sust2", '0, 1'b0, 1'b1, 1'b0, 4'd3);
        boundary("obs3_gone", '0, 1'b0, 1'b0, 1'b0, 4'd3);

        // Obstacles 2 and 5 plus bottom in one frame.
        pixels(5, 1'b1, 8'h24);
        boundary("multi", '0, 1'b1, 1'b1, 1'b1, 4'd2);

        // Boundary pixel belongs to the new frame.
        boundary("sof_px", 8'h80, 1'b0, 1'b0, 1'b0, 4'd2);
        boundary("sof_px_next", '0, 1'b0, 1'b1, 1'b1, 4'd7);

        // Pause: pre-pause obstacle 1 and history on 6 must not leak.
        pixels(6, 1'b0, 8'h40);
        boundary("pre_pause", '0, 1'b0, 1'b1, 1'b1, 4'd6);
        pixels(4, 1'b0, 8'h42);
        pause = 1'b1;
        pixels(4, 1'b0, 8'h42);
        boundary("paused_sof", '0, 1'b0, 1'b0, 1'b0, 4'd6);
        pixels(3, 1'b0, 8'h42);
        pause = 1'b0;
        pixels(4, 1'b0, 8'h40);
        boundary("resume", '0, 1'b0, 1'b1, 1'b1, 4'd6);

        // Bottom armed again; report then reset mid-frame while in holdoff.
        pixels(4, 1'b1, 8'h10);
        boundary("pre_reset", '0, 1'b1, 1'b1, 1'b1, 4'd4);
        pixels(5, 1'b1, 8'h10);
        reset          = 1'b1;
        startOfFrame   = 1'b1;
        smileyDR       = 1'b1;
        borderBottomDR = 1'b1;
        obstacleDR     = 8'h10;
        tick();
        check("reset_mid_sof", outs(), 32'h0);
        startOfFrame = 1'b0;
        tick();
        check("reset_mid", outs(), 32'h0);
        reset          = 1'b0;
        smileyDR       = 1'b0;
        borderBottomDR = 1'b0;
        obstacleDR     = '0;
        tick();
        boundary("post_reset", '0, 1'b0, 1'b0, 1'b0, 4'd0);
        pixels(3, 1'b1, '0);
        boundary("post_reset_armed", '0, 1'b1, 1'b0, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
